// File: rtl/filtro_mac_seq.sv
// filtro_mac_seq: sequential FIR filter with one MAC per cycle, a valid/ready stream interface and writable coefficients
// Ports: clk, rst_n (async active-low); in_valid/in_ready/x_in sample input; coef_we/coef_addr/coef_data coefficient
// write port; y_out/overflow/out_valid/out_ready result output. Build option FILTRO_ROUND_EN rounds each product
// half-up instead of truncating it.
module filtro_mac_seq #(
  parameter int largo = 11,
  parameter int mag   = 4,
  parameter int pres  = 7,
  parameter int TAPS  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [largo:0] x_in,
  input  logic               coef_we,
  input  logic [2:0]         coef_addr,
  input  logic signed [largo:0] coef_data,
  output logic signed [largo:0] y_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overflow
);
  localparam int W = 1 + mag + pres;
  localparam logic signed [W-1:0] P_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] P_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] P_MAX2 = (2*W)'(P_MAX);
  localparam logic signed [2*W-1:0] P_MIN2 = (2*W)'(P_MIN);
  localparam logic [3:0] L_TAPS = 4'(TAPS);
  localparam logic [2:0] L_LAST = 3'(TAPS - 1);
  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;
  state_t r_st, w_nx;
  logic [2:0] r_k;
  logic signed [W-1:0] r_d [TAPS];
  logic signed [W-1:0] r_c [TAPS];
  logic signed [W-1:0] r_acc, r_y, w_p, w_acc;
  logic r_ovf, r_vld, w_accept, w_psat, w_asat;
  logic signed [2*W-1:0] w_prod, w_rnd, w_sh;
  logic [W:0] w_sum;
  assign w_accept = (r_st == IDLE) && in_valid;
  assign w_prod = (2*W)'(r_d[r_k]) * (2*W)'(r_c[r_k]);
`ifdef FILTRO_ROUND_EN
  assign w_rnd = w_prod + (2*W)'(1 << (pres - 1));
`else
  assign w_rnd = w_prod;
`endif
  assign w_sh   = w_rnd >>> pres;
  assign w_psat = (w_sh > P_MAX2) || (w_sh < P_MIN2);
  assign w_p    = (w_sh > P_MAX2) ? P_MAX : (w_sh < P_MIN2) ? P_MIN : w_sh[W-1:0];
  // one guard bit: sign disagreement between the top two bits means the sum left the word range
  assign w_sum  = {r_acc[W-1], r_acc} + {w_p[W-1], w_p};
  assign w_asat = w_sum[W] ^ w_sum[W-1];
  assign w_acc  = !w_asat ? w_sum[W-1:0] : (w_sum[W] ? P_MIN : P_MAX);
  always_comb begin
    w_nx = r_st;
    if (w_accept) w_nx = MAC;
    if (r_st == MAC && r_k == L_LAST) w_nx = HOLD;
    if (r_st == HOLD && r_vld && out_ready) w_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_st <= IDLE;
    else r_st <= w_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= '0;
      r_acc <= '0;
      r_y   <= '0;
      r_ovf <= 1'b0;
      r_vld <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_d[i] <= '0;
        r_c[i] <= (i == 0) ? W'(1 << pres) : '0;
      end
    end else begin
      // the coefficient write lands on the accept edge, so the MAC that follows already sees it
      if (r_st == IDLE && coef_we && {1'b0, coef_addr} < L_TAPS) r_c[coef_addr] <= coef_data;
      if (w_accept) begin
        r_d[0] <= x_in;
        for (int i = 1; i < TAPS; i++) r_d[i] <= r_d[i-1];
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_k   <= '0;
      end
      if (r_st == MAC) begin
        r_acc <= w_acc;
        r_ovf <= r_ovf | w_psat | w_asat;
        r_k   <= r_k + 3'd1;
      end
      // the result is published one cycle after HOLD is entered, giving TAPS+1 cycles of latency
      if (r_st == HOLD && !r_vld) begin
        r_vld <= 1'b1;
        r_y   <= r_acc;
      end
      if (r_st == HOLD && r_vld && out_ready) r_vld <= 1'b0;
    end
  end
  assign in_ready  = (r_st == IDLE);
  assign out_valid = r_vld;
  assign y_out     = r_y;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_filtro_mac_seq.sv
// tb_filtro_mac_seq: scoreboard bench for filtro_mac_seq with a behavioural FIR reference model
module tb_filtro_mac_seq;
  localparam int TAPS = 5;
  localparam int PRES = 7;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, coef_we = 1'b0, out_ready = 1'b0;
  logic [11:0] x_in = '0, coef_data = '0;
  logic [2:0] coef_addr = '0;
  logic [11:0] y_out;
  logic in_ready, out_valid, overflow;
  bit bp_rand = 0, rdy_ctl = 1;
  int cyc = 0, checks = 0, errors = 0;
  int md [TAPS];
  int mc [TAPS];
  typedef struct {logic [11:0] y; bit ov; int cyc;} exp_t;
  exp_t q[$];
  bit pv = 0;
  filtro_mac_seq #(.largo(11), .mag(4), .pres(PRES), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .y_out(y_out),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : rdy_ctl;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic int clamp(input longint v, inout bit ov);
    if (v > 2047) begin ov = 1; return 2047; end
    if (v < -2048) begin ov = 1; return -2048; end
    return int'(v);
  endfunction
  function automatic void mreset();
    for (int k = 0; k < TAPS; k++) begin
      md[k] = 0;
      mc[k] = (k == 0) ? (1 << PRES) : 0;
    end
  endfunction
  // y = sat(sum_k sat(floor(d[k]*c[k] [+ half] / 2^pres))), saturating after every addition
  function automatic void model_accept(input logic [11:0] x, output logic [11:0] y, output bit ov);
    longint p;
    int acc;
    for (int k = TAPS - 1; k > 0; k--) md[k] = md[k-1];
    md[0] = int'($signed(x));
    acc = 0;
    ov = 0;
    for (int k = 0; k < TAPS; k++) begin
      p = longint'(md[k]) * longint'(mc[k]);
`ifdef FILTRO_ROUND_EN
      p = p + (longint'(1) << (PRES - 1));
`endif
      p = p >>> PRES;
      acc = clamp(longint'(acc) + longint'(clamp(p, ov)), ov);
    end
    y = 12'(acc);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) pv = 0;
    else begin
      if (out_valid && !pv) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", cyc - q[0].cyc, TAPS + 1);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("y_out", int'(y_out), int'(e.y));
        chk("overflow", int'(overflow), int'(e.ov));
      end
      pv = out_valid;
    end
  end
  task automatic send(input logic [11:0] x, input bit we = 0, input logic [2:0] a = 0, input logic [11:0] dat = 0);
    bit r, done;
    int n;
    exp_t e;
    in_valid = 1; x_in = x; coef_we = we; coef_addr = a; coef_data = dat;
    done = 0; n = 0;
    while (!done && n < 200) begin
      r = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (r) begin
        if (we && a < 3'(TAPS)) mc[a] = int'($signed(dat));
        model_accept(x, e.y, e.ov);
        e.cyc = cyc;
        q.push_back(e);
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 0; coef_we = 0;
  endtask
  task automatic wcoef(input logic [2:0] a, input logic [11:0] dat);
    bit r;
    coef_we = 1; coef_addr = a; coef_data = dat;
    r = in_ready;
    @(posedge clk);
    #1;
    if (r && a < 3'(TAPS)) mc[a] = int'($signed(dat));
    coef_we = 0;
  endtask
  task automatic drain();
    int n = 0;
    rdy_ctl = 1;
    while ((q.size() != 0 || !in_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
  endtask
  task automatic do_reset();
    drain();
    rst_n = 0;
    #1;
    chk("rst_y_out", int'(y_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    mreset();
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [11:0] y0, x;
    int n;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    send(12'h0C0);
    drain();
    do_reset();
    for (int a = 0; a < TAPS; a++) wcoef(3'(a), 12'h080);
    for (int i = 0; i < 5; i++) send(12'h100);
    drain();
    do_reset();
    for (int a = 0; a < TAPS; a++) wcoef(3'(a), 12'h080);
    send(12'h7FF);
    send(12'h7FF);
    drain();
    do_reset();
    for (int a = 0; a < TAPS; a++) wcoef(3'(a), 12'h080);
    send(12'h800);
    send(12'h800);
    drain();
    do_reset();
    wcoef(3'd0, 12'h040);
    send(12'h001);
    drain();
    do_reset();
    rdy_ctl = 0;
    repeat (2) @(posedge clk);
    #1;
    send(12'h123);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_reached", int'(out_valid), 1);
    y0 = y_out;
    chk("hold_value", int'(y0), (q.size() != 0) ? int'(q[0].y) : -1);
    in_valid = 1; x_in = 12'h055;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_y_out", int'(y_out), int'(y0));
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
    end
    rdy_ctl = 1;
    send(12'h055);
    drain();
    do_reset();
    wcoef(3'd0, 12'h100);
    send(12'h050);
    drain();
    send(12'h0F0, 1'b1, 3'd1, 12'h040);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("abort_y_out", int'(y_out), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_overflow", int'(overflow), 0);
    q.delete();
    mreset();
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    send(12'h0F0);
    drain();
    bp_rand = 1;
    for (int i = 0; i < 80; i++) begin
      x = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($signed(11'($urandom_range(0, 2047)) - 11'sd1024) >>> 2);
      if ($urandom_range(0, 3) == 0)
        send(x, 1'b1, 3'($urandom_range(0, 7)),
             ($urandom_range(0, 4) == 0) ? 12'($urandom) : 12'($urandom_range(0, 511) - 256));
      else send(x);
      if ($urandom_range(0, 2) == 0) wcoef(3'($urandom_range(0, 7)), 12'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    bp_rand = 0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/filtro_mac_seq.md
FILTRO_MAC_SEQ -- requirements
Module: filtro_mac_seq

Interface
- REQ-001 The block SHALL have parameter largo, default 11, meaning MSB index of every sample, coefficient and result word (word width largo+1).
- REQ-002 The block SHALL have parameter mag, default 4, meaning integer magnitude bits of the Q format.
- REQ-003 The block SHALL have parameter pres, default 7, meaning fraction bits of the Q format; 1+mag+pres = largo+1.
- REQ-004 The block SHALL have parameter TAPS, default 5, meaning number of FIR taps (range 2..8).
- REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-007 The block SHALL have port in_valid, input, 1 bit: x_in holds a sample.
- REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample.
- REQ-009 The block SHALL have port x_in, input, largo+1 bits signed: input sample.
- REQ-010 The block SHALL have port coef_we, input, 1 bit: coefficient write strobe.
- REQ-011 The block SHALL have port coef_addr, input, 3 bits: coefficient index.
- REQ-012 The block SHALL have port coef_data, input, largo+1 bits signed: coefficient value.
- REQ-013 The block SHALL have port y_out, output, largo+1 bits signed: filtered result.
- REQ-014 The block SHALL have port out_valid, output, 1 bit: y_out and overflow are valid.
- REQ-015 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the result.
- REQ-016 The block SHALL have port overflow, output, 1 bit: saturation occurred while computing the current y_out.

Function
- REQ-017 The FSM SHALL have states IDLE, MAC and HOLD; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD.
- REQ-018 In IDLE with in_valid=1 the block SHALL shift x_in into delay line d[0], move d[k-1] to d[k], clear the accumulator and overflow, and enter MAC.
- REQ-019 MAC SHALL last exactly TAPS cycles; cycle k SHALL process d[k]*c[k] for k=0..TAPS-1 and then enter HOLD.
- REQ-020 Latency: out_valid SHALL rise TAPS+1 cycles after the accepting edge.
- REQ-021 Each product SHALL be formed at full 2*(largo+1) bits, arithmetically shifted right by pres, then saturated to [-2^largo, 2^largo-1].
- REQ-022 The accumulator update SHALL use a largo+2-bit sum saturated to the same range: positive overflow gives 0x7FF, negative gives 0x800 (default widths).
- REQ-023 overflow SHALL be set by any product or accumulation saturation within a sample and SHALL be cleared only at the next accept.
- REQ-024 In HOLD, y_out and overflow SHALL stay stable until out_ready=1; the block SHALL then return to IDLE on that edge.
- REQ-025 in_valid SHALL be ignored outside IDLE; no sample SHALL be lost or duplicated.
- REQ-026 coef_we SHALL write c[coef_addr] only in IDLE with coef_addr<TAPS; otherwise the write SHALL be ignored.
- REQ-027 If coef_we and an accept occur on the same edge, the write SHALL take effect before the MAC uses the coefficient.

Reset
- REQ-028 With rst_n=0 the block SHALL immediately enter IDLE, set y_out=0, out_valid=0, overflow=0, clear the accumulator and delay line, and set c[0]=2^pres (1.0) and c[1..TAPS-1]=0 (passthrough).
- REQ-029 Reset during MAC or HOLD SHALL abort the computation with no output.
- REQ-030 in_ready SHALL be 1 on the first edge after rst_n is deasserted.

Configuration
- REQ-031 With FILTRO_ROUND_EN defined, each product SHALL add 2^(pres-1) before the shift (round half up); without it, the product SHALL be truncated toward minus infinity.

Verification
- REQ-032 Reset, no coefficient writes, x_in=0x0C0 -> y_out=0x0C0, overflow=0, out_valid 6 cycles after accept.
- REQ-033 All c=0x080, five samples of 0x100 -> y_out = 0x100, 0x200, 0x300, 0x400, 0x500.
- REQ-034 All c=0x080, samples 0x7FF twice -> second y_out=0x7FF with overflow=1; same test with 0x800 -> 0x800 with overflow=1.
- REQ-035 out_ready=0 for 10 cycles in HOLD while in_valid=1 -> y_out stable, in_ready=0, no sample accepted.
- REQ-036 rst_n pulsed low in MAC cycle 2 -> all outputs 0 immediately, and the next sample passes through unchanged (c back to default).
- REQ-037 c[0]=0x040, x_in=0x001 -> y_out=0x000 without FILTRO_ROUND_EN and 0x001 with it.
